fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 imemload  input  32  instruction word from instruction memory.
REQ-006 stall  input  1  decode stage cannot accept a new instruction; IF/ID contents hold.
REQ-007 redirect  input  1  branch/jump resolved taken; fetch from redirect_pc.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 iREN  output  1  instruction read enable to memory.
REQ-010 imemaddr  output  32  fetch address (current PC).
REQ-011 instr_out  output  32  IF/ID instruction word feeding the decode/control stage.
REQ-012 pc_out  output  32  PC of instr_out.
REQ-013 npc_out  output  32  pc_out + 4.
REQ-014 valid_out  output  1  instr_out is a real instruction (0 = bubble).

Function
REQ-015 FSM states FETCH, HALTED; reset state FETCH.
REQ-016 iREN = 1 in FETCH and 0 in HALTED; imemaddr = PC at all times.
REQ-017 Memory request is level-based: iREN/imemaddr held until ihit; miss latency is unbounded.
REQ-018 FETCH, ihit=1, stall=0, redirect=0: IF/ID loads {imemload, PC, PC+4, valid=1} and PC <= PC+4 at the same edge (1-cycle latency on hit).
REQ-019 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0); no overflow flag.
REQ-020 FETCH, ihit=0, stall=0, redirect=0: IF/ID loads bubble {instr 0, valid 0, pc/npc unchanged}; PC holds.
REQ-021 stall=1, redirect=0: IF/ID and PC hold; ihit is ignored and the word re-fetched after stall drops.
REQ-022 redirect=1 has priority over stall and ihit: PC <= {redirect_pc[31:2], 2'b00}; IF/ID loads bubble; state <= FETCH; any same-cycle fetched word is dropped.
REQ-023 A hit word with opcode [31:26] = HALT is latched per REQ-018, PC still advances, and state <= HALTED.
REQ-024 HALTED, stall=0, redirect=0: IF/ID loads bubble; PC holds; remains HALTED.
REQ-025 HALTED exits only on redirect (wrong-path halt squashed) or RST.
REQ-026 All outputs are registered or direct decode of state/PC; no combinational path from ihit/imemload to outputs.

Reset
REQ-027 RST=1 asynchronously sets PC=RESET_PC, state=FETCH, instr_out=0, pc_out=0, npc_out=0, valid_out=0; iREN=1 and imemaddr=RESET_PC once RST deasserts.
REQ-028 RST asserted mid-miss or mid-stall discards the pending fetch; first request after release is RESET_PC.

Structure
REQ-029 Opcode type, HALT encoding and 32-bit word type come from cpu_types_pkg; no new package constants required.
REQ-030 FSM state enum is local to fetch_stage.
REQ-031 IF/ID register is one sub-module, if_id_latch, with enable (load), flush (bubble) and async RST inputs.

Verification
REQ-032 Reset: RST pulse mid-cycle -> outputs zero immediately; imemaddr=0, iREN=1 after release.
REQ-033 Streaming hits: ihit=1 at 0x0,0x4,0x8 -> valid_out=1 on three consecutive cycles, pc_out 0,4,8, npc_out 4,8,C.
REQ-034 Miss: ihit low 3 cycles at 0x10 -> three bubbles, imemaddr stays 0x10, instruction appears cycle after ihit.
REQ-035 Stall: stall=1 for 2 cycles with pc_out=0x20 -> instr_out/pc_out unchanged, imemaddr held at 0x24.
REQ-036 Redirect during miss plus stall: redirect=1, redirect_pc=0x103, stall=1 -> next cycle imemaddr=0x100, valid_out=0.
REQ-037 Halt: HALT word fetched at 0x40 -> valid HALT latched, iREN=0 next cycle, bubbles follow; redirect to 0x80 -> iREN=1, imemaddr=0x80.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word and opcode types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

endpackage

// File: rtl/if_id_latch.sv
// rtl/if_id_latch.sv - IF/ID pipeline register with load and bubble flush
import cpu_types_pkg::*;

module if_id_latch (
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  flush,
    input  word_t instr,
    input  word_t pc,
    input  word_t npc,
    output word_t instr_out,
    output word_t pc_out,
    output word_t npc_out,
    output logic  valid_out
);

    // A bubble clears only the instruction and valid bit; pc/npc keep
    // their last values so decode always sees a stable address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_out <= '0;
            pc_out    <= '0;
            npc_out   <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            instr_out <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            instr_out <= instr;
            pc_out    <= pc;
            npc_out   <= npc;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, halt FSM and IF/ID register
import cpu_types_pkg::*;

module fetch_stage #(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  iREN,
    output word_t imemaddr,
    output word_t instr_out,
    output word_t pc_out,
    output word_t npc_out,
    output logic  valid_out
);

    typedef enum logic {
        FETCH,
        HALTED
    } state_t;

    state_t state, next_state;
    word_t  pc, pc_next, pc_plus4;
    logic   load, flush;

    assign pc_plus4 = pc + 32'd4;
    assign iREN     = (state == FETCH);
    assign imemaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Redirect beats stall beats hit; a halted stage only wakes on redirect.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            flush      = 1'b1;
            next_state = FETCH;
        end else if (!stall) begin
            if (state == FETCH && ihit) begin
                load    = 1'b1;
                pc_next = pc_plus4;
                if (opcode_t'(imemload[31:26]) == HALT)
                    next_state = HALTED;
            end else begin
                flush = 1'b1;
            end
        end
    end

    if_id_latch u_if_id (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .flush     (flush),
        .instr     (imemload),
        .pc        (pc),
        .npc       (pc_plus4),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .npc_out   (npc_out),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        iREN;
    logic [31:0] imemaddr, instr_out, pc_out, npc_out;
    logic        valid_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_instr, m_pco, m_npc;
    logic        m_valid, m_halt;

    fetch_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".iREN"},      {31'd0, iREN},      {31'd0, ~m_halt});
        chk({tag, ".imemaddr"},  imemaddr,           m_pc);
        chk({tag, ".instr_out"}, instr_out,          m_instr);
        chk({tag, ".pc_out"},    pc_out,             m_pco);
        chk({tag, ".npc_out"},   npc_out,            m_npc);
        chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, m_valid});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_pco = '0; m_npc = '0;
        m_valid = 1'b0; m_halt = 1'b0;
    endtask

    // Plain-language rules: a redirect always wins, a stall freezes
    // everything, otherwise a running fetch either takes the word or inserts a bubble.
    task automatic model_edge(input logic h, input logic s, input logic r,
                              input logic [31:0] rp, input logic [31:0] w);
        if (r) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_halt = 1'b0; m_valid = 1'b0; m_instr = '0;
        end else if (s) begin
        end else if (!m_halt && h) begin
            m_instr = w; m_pco = m_pc; m_npc = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (w[31:26] == 6'h3F) m_halt = 1'b1;
        end else begin
            m_valid = 1'b0; m_instr = '0;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic is_halt);
        return is_halt ? {6'h3F, a[25:0]} : {6'h08, a[25:0] ^ 26'h155_5555};
    endfunction

    task automatic step(input string tag, input logic h, input logic s, input logic r,
                        input logic [31:0] rp, input logic is_halt);
        logic [31:0] w;
        w = mem_word(m_pc, is_halt);
        ihit = h; stall = s; redirect = r; redirect_pc = rp; imemload = w;
        @(posedge CLK);
        model_edge(h, s, r, rp, w);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all({tag, ".release"});
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all("reset_release");

        for (int i = 0; i < 3; i++) step("stream", 1, 0, 0, 0, 0);
        step("hit_c", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("miss", 0, 0, 0, 0, 0);
        step("miss_hit", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("to_20", 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("stall", 1, 1, 0, 0, 0);
        step("redir_stall", 0, 1, 1, 32'h103, 0);
        step("redir_40", 0, 0, 1, 32'h40, 0);
        step("halt_hit", 1, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) step("halted", 1, 0, 0, 0, 0);
        step("halted_stall", 1, 1, 0, 0, 0);
        step("halt_exit", 0, 0, 1, 32'h80, 0);
        step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFE, 0);
        step("wrap_hit", 1, 0, 0, 0, 0);
        step("wrap_next", 1, 0, 0, 0, 0);
        step("pre_rst_miss", 0, 0, 0, 0, 0);
        do_reset("rst_miss");
        step("pre_rst_stall", 1, 1, 0, 0, 0);
        do_reset("rst_stall");

        for (int i = 0; i < 400; i++) begin
            logic h, s, r, hw;
            h  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 9) < 2);
            r  = ($urandom_range(0, 99) < 8);
            hw = ($urandom_range(0, 99) < 5);
            step("rand", h, s, r, $urandom, hw);
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
